// File: rtl/cmp_decimator_if.sv
// rtl/cmp_decimator_if.sv - result handshake bundle between decimator and consumer
interface cmp_decimator_if #(
    parameter int OUT_W = 9
);
    logic [OUT_W-1:0] result;
    logic             result_valid;
    logic             result_ack;
    logic             overrun;

    modport master (
        output result,
        output result_valid,
        output overrun,
        input  result_ack
    );

    modport slave (
        input  result,
        input  result_valid,
        input  overrun,
        output result_ack
    );
endinterface

// File: rtl/cmp_decimator.sv
// rtl/cmp_decimator.sv - comparator resync, deglitch and windowed ones-count decimator
module cmp_decimator #(
    parameter int SYNC_STAGES = 2,
    parameter int DEGLITCH    = 3,
    parameter int WIN_BITS    = 8,
    parameter int OUT_W       = WIN_BITS + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_in,
    input  logic             en,
    input  logic             sample_en,
    output logic             cmp_q,
    output logic             edge_rise,
    output logic             edge_fall,
    cmp_decimator_if.master  res
);

    localparam int GW = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
    localparam logic [GW-1:0]       G_LAST = GW'(DEGLITCH - 1);
    localparam logic [WIN_BITS-1:0] N_LAST = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 s;
    logic [GW-1:0]        gcnt;
    logic [OUT_W-1:0]     acc;
    logic [WIN_BITS-1:0]  n;
    logic                 do_sample;
    logic                 win_end;
    logic                 clr_win;
    logic [OUT_W-1:0]     result_r;
    logic                 valid_r;
    logic                 overrun_r;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous comparator bit through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
        end
    end

    // Flip the filtered level only after DEGLITCH consecutive disagreeing clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q     <= 1'b0;
            gcnt      <= '0;
            edge_rise <= 1'b0;
            edge_fall <= 1'b0;
        end else begin
            edge_rise <= 1'b0;
            edge_fall <= 1'b0;
            if (s != cmp_q && gcnt == G_LAST) begin
                cmp_q     <= s;
                gcnt      <= '0;
                edge_rise <= s;
                edge_fall <= ~s;
            end else if (s != cmp_q) begin
                gcnt <= gcnt + 1'b1;
            end else begin
                gcnt <= '0;
            end
        end
    end

    // Accumulation state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: en alone decides between idling and accumulating
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en)  state_nx = ACCUM;
            ACCUM:   if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Decode per-state control: sampling, window end, and partial-window discard
    always_comb begin
        do_sample = 1'b0;
        win_end   = 1'b0;
        clr_win   = 1'b1;
        if (state == ACCUM) begin
            do_sample = sample_en;
            win_end   = sample_en && (n == N_LAST);
            clr_win   = !en || (sample_en && (n == N_LAST));
        end
    end

    // Window accumulator and sample counter; cleared at window end, abort and in IDLE
    always_ff @(posedge clk) begin
        if (rst || clr_win) begin
            acc <= '0;
            n   <= '0;
        end else if (do_sample) begin
            acc <= acc + OUT_W'(cmp_q);
            n   <= n + 1'b1;
        end
    end

    // Result register with valid/ack handshake; completion wins over a coincident ack
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r  <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (win_end) begin
            result_r  <= acc + OUT_W'(cmp_q);
            valid_r   <= 1'b1;
            overrun_r <= valid_r && !res.result_ack;
        end else if (res.result_ack && valid_r) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end
    end

    assign res.result       = result_r;
    assign res.result_valid = valid_r;
    assign res.overrun      = overrun_r;

endmodule

// File: tb/tb_cmp_decimator.sv
// tb/tb_cmp_decimator.sv - directed self-checking bench for cmp_decimator
module tb_cmp_decimator;

    logic clk = 1'b0;
    logic rst;
    logic cmp_in;
    logic en;
    logic sample_en;
    logic cmp_q;
    logic edge_rise;
    logic edge_fall;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cmp_decimator_if #(.OUT_W(9)) rif ();

    cmp_decimator #(
        .SYNC_STAGES(2),
        .DEGLITCH   (3),
        .WIN_BITS   (8),
        .OUT_W      (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmp_in    (cmp_in),
        .en        (en),
        .sample_en (sample_en),
        .cmp_q     (cmp_q),
        .edge_rise (edge_rise),
        .edge_fall (edge_fall),
        .res       (rif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_ack();
        rif.result_ack = 1'b1;
        tick();
        rif.result_ack = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!rif.result_valid && cnt < 400);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmp_in = 1'b0; en = 1'b0; sample_en = 1'b0; rif.result_ack = 1'b0;
        ticks(3);
        total_cnt++;
        if ({cmp_q, edge_rise, edge_fall, rif.result_valid, rif.overrun} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {cmp_q, edge_rise, edge_fall, rif.result_valid, rif.overrun});
        else pass_cnt++;
        total_cnt++;
        if (rif.result !== 9'd0) $display("FAIL reset_result got=%0d exp=0", rif.result);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_step_latency();
        int rise_at = 0;
        int pulse_at = 0;
        int nr = 0;
        int nf = 0;
        cmp_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (edge_rise) begin nr++; pulse_at = k; end
            if (edge_fall) nf++;
            if (cmp_q && rise_at == 0) rise_at = k;
        end
        total_cnt++;
        if (rise_at !== 5) $display("FAIL step_latency got=%0d exp=5", rise_at);
        else pass_cnt++;
        total_cnt++;
        if (nr !== 1 || pulse_at !== 5) $display("FAIL step_rise_pulse got=%0d@%0d exp=1@5", nr, pulse_at);
        else pass_cnt++;
        total_cnt++;
        if (nf !== 0) $display("FAIL step_no_fall got=%0d exp=0", nf);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int highs = 0;
        int nr = 0;
        int nf = 0;
        cmp_in = 1'b0;
        ticks(10);
        total_cnt++;
        if (cmp_q !== 1'b0) $display("FAIL glitch_settle got=%b exp=0", cmp_q);
        else pass_cnt++;
        cmp_in = 1'b1;
        ticks(2);
        cmp_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cmp_q) highs++;
            if (edge_rise) nr++;
            if (edge_fall) nf++;
        end
        total_cnt++;
        if (highs !== 0 || nr !== 0 || nf !== 0)
            $display("FAIL glitch_2clk got=%0d/%0d/%0d exp=0/0/0", highs, nr, nf);
        else pass_cnt++;
        highs = 0; nr = 0; nf = 0;
        cmp_in = 1'b1;
        ticks(3);
        cmp_in = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (cmp_q) highs++;
            if (edge_rise) nr++;
            if (edge_fall) nf++;
        end
        total_cnt++;
        if (highs !== 3) $display("FAIL glitch_3clk_width got=%0d exp=3", highs);
        else pass_cnt++;
        total_cnt++;
        if (nr !== 1 || nf !== 1) $display("FAIL glitch_3clk_edges got=%0d/%0d exp=1/1", nr, nf);
        else pass_cnt++;
    endtask

    task automatic test_window(input logic lvl, input int exp_res);
        int cnt;
        cmp_in = lvl;
        ticks(10);
        en = 1'b1; sample_en = 1'b1;
        wait_valid(cnt);
        total_cnt++;
        if (cnt !== 257) $display("FAIL window_latency lvl=%b got=%0d exp=257", lvl, cnt);
        else pass_cnt++;
        total_cnt++;
        if (rif.result !== 9'(exp_res) || rif.overrun !== 1'b0)
            $display("FAIL window_result lvl=%b got=%0d ovr=%b exp=%0d ovr=0", lvl, rif.result, rif.overrun, exp_res);
        else pass_cnt++;
        do_ack();
        total_cnt++;
        if (rif.result_valid !== 1'b0) $display("FAIL window_ack got=%b exp=0", rif.result_valid);
        else pass_cnt++;
        en = 1'b0;
        tick();
    endtask

    task automatic test_duty();
        int res_q[$];
        en = 1'b1; sample_en = 1'b1;
        for (int cyc = 0; cyc < 900; cyc++) begin
            cmp_in = ((cyc >> 3) & 1) != 0;
            rif.result_ack = 1'b0;
            if (rif.result_valid) begin
                res_q.push_back(int'(rif.result));
                rif.result_ack = 1'b1;
            end
            tick();
        end
        rif.result_ack = 1'b0;
        total_cnt++;
        if (res_q.size() < 3) $display("FAIL duty_windows got=%0d exp>=3", res_q.size());
        else pass_cnt++;
        for (int w = 1; w < 3; w++) begin
            total_cnt++;
            if (w < res_q.size() && res_q[w] == 128) pass_cnt++;
            else $display("FAIL duty_result w=%0d got=%0d exp=128", w, (w < res_q.size()) ? res_q[w] : -1);
        end
        total_cnt++;
        if (rif.overrun !== 1'b0) $display("FAIL duty_overrun got=%b exp=0", rif.overrun);
        else pass_cnt++;
        en = 1'b0;
        tick();
        if (rif.result_valid) do_ack();
    endtask

    task automatic test_overrun();
        int cnt;
        cmp_in = 1'b1;
        ticks(10);
        en = 1'b1; sample_en = 1'b1;
        wait_valid(cnt);
        total_cnt++;
        if (rif.result !== 9'd256) $display("FAIL ovr_first got=%0d exp=256", rif.result);
        else pass_cnt++;
        cmp_in = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!rif.overrun && cnt < 400);
        total_cnt++;
        if (cnt !== 256) $display("FAIL ovr_timing got=%0d exp=256", cnt);
        else pass_cnt++;
        total_cnt++;
        if (rif.result !== 9'd5 || rif.result_valid !== 1'b1 || rif.overrun !== 1'b1)
            $display("FAIL ovr_second got=%0d v=%b o=%b exp=5 v=1 o=1", rif.result, rif.result_valid, rif.overrun);
        else pass_cnt++;
        ticks(255);
        do_ack();
        total_cnt++;
        if (rif.result !== 9'd0 || rif.result_valid !== 1'b1 || rif.overrun !== 1'b0)
            $display("FAIL ack_with_completion got=%0d v=%b o=%b exp=0 v=1 o=0", rif.result, rif.result_valid, rif.overrun);
        else pass_cnt++;
        en = 1'b0;
        tick();
        do_ack();
        total_cnt++;
        if (rif.result_valid !== 1'b0 || rif.overrun !== 1'b0)
            $display("FAIL ack_alone got=v%b o%b exp=v0 o0", rif.result_valid, rif.overrun);
        else pass_cnt++;
        do_ack();
        total_cnt++;
        if (rif.result_valid !== 1'b0) $display("FAIL ack_idle got=%b exp=0", rif.result_valid);
        else pass_cnt++;
    endtask

    task automatic test_abort_and_reset();
        int cnt;
        cmp_in = 1'b1;
        ticks(10);
        en = 1'b1; sample_en = 1'b1;
        ticks(101);
        en = 1'b0;
        ticks(5);
        total_cnt++;
        if (rif.result_valid !== 1'b0) $display("FAIL abort_no_result got=%b exp=0", rif.result_valid);
        else pass_cnt++;
        en = 1'b1;
        wait_valid(cnt);
        total_cnt++;
        if (cnt !== 257 || rif.result !== 9'd256)
            $display("FAIL abort_fresh got=%0d cyc=%0d exp=256 cyc=257", rif.result, cnt);
        else pass_cnt++;
        ticks(50);
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({cmp_q, edge_rise, edge_fall, rif.result_valid, rif.overrun} !== 5'b0 || rif.result !== 9'd0)
            $display("FAIL midreset got=%b res=%0d exp=00000 res=0",
                     {cmp_q, edge_rise, edge_fall, rif.result_valid, rif.overrun}, rif.result);
        else pass_cnt++;
        rst = 1'b0;
        wait_valid(cnt);
        total_cnt++;
        if (cnt !== 257 || rif.result !== 9'd252)
            $display("FAIL post_reset_window got=%0d cyc=%0d exp=252 cyc=257", rif.result, cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_step_latency();
        test_glitch();
        test_window(1'b1, 256);
        test_window(1'b0, 0);
        test_duty();
        test_overrun();
        test_abort_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cmp_decimator.md
Name: cmp_decimator

Overview:
- Downstream consumer of the gate-level comparator's single-bit decision output.
- Resynchronises the asynchronous comparator bit into the clk domain and removes glitches with a consecutive-sample filter.
- Counts filtered ones over a fixed window of sample strobes, a first-order sigma-delta style decimation.
- Presents each window count as a multi-bit result with a valid/ack handshake and a sticky overrun flag.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on cmp_in (>=2).
- DEGLITCH, 3, consecutive clocks the synchronized value must differ before the filtered level flips (>=1).
- WIN_BITS, 8, window length is 2^WIN_BITS sample strobes.
- OUT_W, WIN_BITS+1, result width; holds 0..2^WIN_BITS inclusive.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- cmp_in  input  1  asynchronous comparator decision bit.
- en  input  1  enable windowed accumulation.
- sample_en  input  1  one-cycle sample strobe; accumulation advances only when high.
- result_ack  input  1  consumer acknowledges result; clears result_valid and overrun.
- cmp_q  output  1  synchronized, deglitched comparator level.
- edge_rise  output  1  one-cycle pulse when cmp_q goes 0->1.
- edge_fall  output  1  one-cycle pulse when cmp_q goes 1->0.
- result  output  OUT_W  ones count of the last completed window.
- result_valid  output  1  result holds an unacknowledged window.
- overrun  output  1  sticky: a window completed while result_valid was high and unacked.

Behaviour:
- Reset values: all outputs, synchronizer flops, deglitch counter, accumulator and sample counter are 0. Reset dominates all other inputs in the same cycle. Reset mid-window discards the partial window.
- Synchronizer:
  - s is SYNC_STAGES flops in series and runs every clock.
  - s reflects cmp_in SYNC_STAGES edges after the first edge that captures the new level.
- Deglitch, every clock:
  - If s != cmp_q and gcnt == DEGLITCH-1: cmp_q <= s, gcnt <= 0, and the matching edge pulse is asserted for that one cycle.
  - Else if s != cmp_q: gcnt++.
  - Else: gcnt <= 0.
- Latency: a clean cmp_in step reaches cmp_q SYNC_STAGES+DEGLITCH edges after capture (5 with defaults). Pulses shorter than DEGLITCH clocks at s never reach cmp_q.
- States: IDLE and ACCUM.
  - IDLE: acc = 0, n = 0. en=1 moves to ACCUM on the next edge. No sample is taken on the transition edge.
  - ACCUM, on a sample_en edge: acc += cmp_q, using the pre-edge value of cmp_q, and n++.
  - When n == 2^WIN_BITS-1 and sample_en: result <= acc + cmp_q, result_valid <= 1, acc <= 0, n <= 0, and the state stays ACCUM. Windows run back to back.
  - en=0 in ACCUM: go to IDLE on the next edge and discard the partial window. result, result_valid and overrun are untouched.
  - sample_en is ignored in IDLE.
- Width rules:
  - acc is OUT_W bits and never wraps; its maximum is 2^WIN_BITS.
  - n is WIN_BITS bits and wraps only through the explicit window-end clear.
- Handshake and simultaneous events:
  - result_ack alone: result_valid <= 0, overrun <= 0. result holds its value.
  - Window completion with result_valid=1 and no ack: result is overwritten, result_valid stays 1, overrun <= 1.
  - Window completion in the same cycle as ack: the new result loads, result_valid stays 1, overrun <= 0.
  - Ack while result_valid=0 has no effect.
- result changes only on window completion or reset.

Test Plan:
1. Step latency: rst, then hold cmp_in=1 -> cmp_q rises exactly 5 clocks after the first capturing edge. edge_rise is high for 1 cycle. edge_fall stays 0.
2. Glitch rejection: cmp_q=0, cmp_in high for 2 clocks -> cmp_q stays 0 and no edge pulses. A 3-clock pulse -> cmp_q is high for exactly 3 cycles.
3. Full and empty windows:
   - cmp_in=1 settled 10 cycles, then en=1 with sample_en every cycle -> after 256 samples result=256, result_valid=1.
   - Same test with cmp_in=0 -> result=0.
4. Duty measurement: en=1, sample_en every cycle, cmp_in square wave 8 high / 8 low -> each steady-state window reports result=128.
5. Handshake and overrun:
   - Leave the result unacked across two windows -> overrun=1 and result holds the second window.
   - Ack -> result_valid=0, overrun=0.
   - Ack coincident with a completion -> result_valid=1, overrun=0.
6. Abort and reset:
   - Drop en after 100 samples, then re-enable -> the next result counts a full fresh 256-sample window.
   - Assert rst mid-window -> all outputs 0 on the next edge.
